gol_cell_mem_arbiter: RTL and testbench
=======================================

Name: gol_cell_mem_arbiter

Overview:
- Arbitrates one single-port, double-banked cell RAM between two requesters:
  - the VGA pixel fetch path (display), which reads the front bank;
  - the Game of Life generation engine, which reads the front bank and reads/writes the back bank.
- Display always has priority; the engine fills idle cycles.
- Swaps front/back banks only at the start of vertical blanking, so a frame never shows a half-written generation.
- Sits between the VGA timing/pixel path and the cell RAM.

Parameters:
- ADDR_W, 13, cell address width per bank (80x60 = 4800 cells fits).
- DATA_W, 1, bits per RAM word.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- in_blank  input  1  1 while the vertical counter is outside the visible region (from timing path)
- disp_req  input  1  display read request this cycle
- disp_addr  input  ADDR_W  display cell address (front bank implied)
- disp_rdata  output  DATA_W  display read data
- disp_rvalid  output  1  disp_rdata valid, one-cycle pulse
- eng_req  input  1  engine access request, held until granted
- eng_we  input  1  1 = write, 0 = read
- eng_bank  input  1  0 = front, 1 = back
- eng_addr  input  ADDR_W  engine cell address
- eng_wdata  input  DATA_W  engine write data
- eng_gnt  output  1  engine access accepted this cycle (combinational)
- eng_rdata  output  DATA_W  engine read data
- eng_rvalid  output  1  eng_rdata valid, one-cycle pulse
- gen_done  input  1  pulse: engine finished writing the next generation into the back bank
- swap_ack  output  1  pulse: banks swapped this cycle
- swap_pending  output  1  swap requested, waiting for blank
- bank_sel  output  1  physical bank currently front
- gen_cnt  output  16  completed swaps, wraps 0xFFFF->0
- eng_wr_err  output  1  sticky: engine attempted a front-bank write
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDR_W+1  {physical bank, cell address}
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, 1-cycle latency after mem_en & ~mem_we

Behaviour:
- Reset, synchronous:
  - bank_sel=0, swap_pending=0, gen_cnt=0, eng_wr_err=0.
  - blank_q=0; the in-flight read tag is cleared.
  - disp_rvalid, eng_rvalid and swap_ack are 0 on the cycle after rst is sampled.
  - While rst=1: eng_gnt=0, mem_en=0.
  - A read issued before reset never produces rvalid.
- Arbitration, combinational per cycle, strict priority:
  - disp_req=1: mem_en=1, mem_we=0, mem_addr={bank_sel, disp_addr}, eng_gnt=0.
  - Else eng_req=1: eng_gnt=1, mem_en=1, mem_we=eng_we, mem_addr={bank_sel^eng_bank, eng_addr}, mem_wdata=eng_wdata.
  - Else: mem_en=0, mem_we=0.
- Front-bank writes (eng_req & eng_we & eng_bank=0 when granted):
  - eng_gnt=1 (the engine is not stalled), but mem_en=0 and mem_we=0, so the write is dropped.
  - eng_wr_err sets next cycle and holds until reset.
- Read return:
  - A 2-bit tag {disp, eng} is registered at each read issue.
  - The next cycle, exactly one of disp_rvalid/eng_rvalid pulses.
  - Both rdata outputs mirror mem_rdata; consumers qualify with rvalid.
  - Back-to-back reads give one rvalid per cycle at full throughput.
- Swap FSM, states RUN and PEND:
  - blank_rise = in_blank & ~blank_q, where blank_q is in_blank registered.
  - RUN: gen_done=1 and no blank_rise -> PEND. gen_done=1 with blank_rise -> swap directly.
  - PEND: blank_rise -> swap, back to RUN. Further gen_done pulses are ignored (no double swap).
  - Swap cycle: bank_sel toggles at the clock edge, swap_ack=1 for one cycle, gen_cnt+1 (mod 2^16).
  - swap_pending=1 exactly while in PEND.
- Swap boundaries:
  - Accesses issued in the swap cycle use the old bank_sel.
  - Reads in flight across a swap return data from the bank they were issued to.
  - in_blank held high with no new rise never triggers a swap.
- Reset mid-swap: PEND is abandoned, bank_sel returns to 0.

Test Plan:
- Reset, then disp_req=1 with disp_addr=0x005 and mem_rdata model returning 1 -> mem_addr=0x0005; disp_rvalid=1 with disp_rdata=1 next cycle; eng_rvalid=0.
- disp_req=1 and eng_req=1 (read, back bank) held for 3 cycles, then disp_req=0 -> eng_gnt=0 for 3 cycles, then 1 with mem_addr=0x2000|eng_addr; eng_rvalid one cycle later.
- Engine write with eng_bank=0, addr 0x010 -> eng_gnt=1, mem_en=0, eng_wr_err=1 next cycle; it stays 1 until rst.
- gen_done pulse with in_blank=0 -> swap_pending=1. in_blank 0->1 -> swap_ack pulse, bank_sel=1, gen_cnt=1. A display read to 0x003 afterwards drives mem_addr=0x2003.
- gen_done on the same cycle as the blank rising edge -> swap that cycle. A second gen_done while PEND -> one swap only, gen_cnt increments by 1.
- Assert rst while PEND, and again one cycle after a read issue -> no rvalid, swap_pending=0, bank_sel=0, gen_cnt=0. Preload gen_cnt to 0xFFFF via 65535 swaps, then swap again -> wraps to 0.

Source files
------------

// File: rtl/gol_cell_mem_arbiter.sv
`default_nettype none
// ============================================================================
// gol_cell_mem_arbiter : display-priority arbiter and front/back bank swapper
//                        for the double-banked Game of Life cell RAM
// Rev 1.0
// ============================================================================
module gol_cell_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic              eng_bank,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_rvalid,
  input  logic              gen_done,
  output logic              swap_ack,
  output logic              swap_pending,
  output logic              bank_sel,
  output logic [15:0]       gen_cnt,
  output logic              eng_wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        bank_sel_q, bank_sel_d;
  logic [15:0] gen_cnt_q, gen_cnt_d;
  logic        eng_wr_err_q, eng_wr_err_d;
  logic        blank_q, blank_d;
  logic        swap_ack_q, swap_ack_d;
  logic [1:0]  tag_q, tag_d;
  logic        blank_rise;
  logic        do_swap;
  logic        front_wr;
  logic        rd_issue;

  always_comb begin
    eng_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = eng_wdata;
    front_wr  = 1'b0;
    if (!rst) begin
      if (disp_req) begin
        mem_en   = 1'b1;
        mem_addr = {bank_sel_q, disp_addr};
      end else if (eng_req) begin
        eng_gnt  = 1'b1;
        mem_addr = {bank_sel_q ^ eng_bank, eng_addr};
        // Front-bank writes are acknowledged so the engine never stalls, but dropped.
        if (eng_we && !eng_bank) begin
          front_wr = 1'b1;
        end else begin
          mem_en = 1'b1;
          mem_we = eng_we;
        end
      end
    end
  end

  always_comb begin
    blank_rise   = in_blank & ~blank_q;
    blank_d      = in_blank;
    rd_issue     = mem_en & ~mem_we;
    tag_d        = {rd_issue & disp_req, rd_issue & ~disp_req};
    eng_wr_err_d = eng_wr_err_q | front_wr;
    state_d      = state_q;
    do_swap      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (gen_done) begin
          if (blank_rise) do_swap = 1'b1;
          else            state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (blank_rise) begin
          do_swap = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    bank_sel_d = do_swap ? ~bank_sel_q : bank_sel_q;
    gen_cnt_d  = do_swap ? gen_cnt_q + 16'd1 : gen_cnt_q;
    swap_ack_d = do_swap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      bank_sel_q   <= 1'b0;
      gen_cnt_q    <= 16'd0;
      eng_wr_err_q <= 1'b0;
      blank_q      <= 1'b0;
      swap_ack_q   <= 1'b0;
      tag_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      bank_sel_q   <= bank_sel_d;
      gen_cnt_q    <= gen_cnt_d;
      eng_wr_err_q <= eng_wr_err_d;
      blank_q      <= blank_d;
      swap_ack_q   <= swap_ack_d;
      tag_q        <= tag_d;
    end
  end

  // Masking with rst drops a read that was issued just before reset.
  assign disp_rvalid  = tag_q[1] & ~rst;
  assign eng_rvalid   = tag_q[0] & ~rst;
  assign disp_rdata   = mem_rdata;
  assign eng_rdata    = mem_rdata;
  assign swap_ack     = swap_ack_q;
  assign swap_pending = (state_q == ST_PEND);
  assign bank_sel     = bank_sel_q;
  assign gen_cnt      = gen_cnt_q;
  assign eng_wr_err   = eng_wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_gol_cell_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_gol_cell_mem_arbiter : randomized scoreboard bench for gol_cell_mem_arbiter
// Rev 1.0
// ============================================================================
module tb_gol_cell_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 1;

  logic          clk = 1'b0;
  logic          rst, in_blank, disp_req, eng_req, eng_we, eng_bank, gen_done;
  logic [AW-1:0] disp_addr, eng_addr;
  logic [DW-1:0] eng_wdata, disp_rdata, eng_rdata, mem_wdata, mem_rdata;
  logic          disp_rvalid, eng_gnt, eng_rvalid, swap_ack, swap_pending, bank_sel;
  logic [15:0]   gen_cnt;
  logic          eng_wr_err, mem_en, mem_we;
  logic [AW:0]   mem_addr;

  always #5 clk = ~clk;

  gol_cell_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_blank(in_blank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .eng_req(eng_req), .eng_we(eng_we), .eng_bank(eng_bank), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_gnt(eng_gnt), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .gen_done(gen_done), .swap_ack(swap_ack), .swap_pending(swap_pending), .bank_sel(bank_sel),
    .gen_cnt(gen_cnt), .eng_wr_err(eng_wr_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Unwritten cells hold a fixed pseudo-random pattern so every address reads distinctively.
  function automatic logic [DW-1:0] pat(input logic [AW:0] a);
    logic [31:0] p;
    p = ({18'd0, a} + 32'd1) * 32'h9E3779B1;
    return DW'(^p[31:16]);
  endfunction

  // Single-port RAM, one cycle read latency.
  logic [DW-1:0] ram [int];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else ram_q <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pat(mem_addr);
    end
  end
  assign mem_rdata = ram_q;

  // Reference model: logical front bank, pending flag, generation count, expected cell contents.
  logic [DW-1:0] shadow [int];
  logic          m_front, m_pend, m_blank, m_err, m_ack;
  logic [15:0]   m_cnt;

  typedef struct {
    bit            is_disp;
    logic [DW-1:0] data;
    time           t;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] sh_rd(input logic [AW:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : pat(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a read pushed at issue must return exactly one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (disp_rvalid || eng_rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got disp=%0b eng=%0b expected none at %0t",
                 disp_rvalid, eng_rvalid, $time);
      end else begin
        e = sb.pop_front();
        if (($time - e.t) != 11 || disp_rvalid !== e.is_disp || eng_rvalid !== !e.is_disp ||
            (e.is_disp ? disp_rdata : eng_rdata) !== e.data) begin
          errors++;
          $display("FAIL read_return: got disp_v=%0b eng_v=%0b data=%0h age=%0t expected disp=%0b data=%0h age=11",
                   disp_rvalid, eng_rvalid, e.is_disp ? disp_rdata : eng_rdata, $time - e.t,
                   e.is_disp, e.data);
        end
      end
    end else if (sb.size() > 0 && ($time - sb[0].t) >= 11) begin
      checks++;
      errors++;
      $display("FAIL missing_rvalid: got none expected %s read issued at %0t",
               sb[0].is_disp ? "disp" : "eng", sb[0].t);
      void'(sb.pop_front());
    end
  end

  // One clock cycle: inputs already applied at posedge+2.
  task automatic tick();
    logic        exp_gnt, exp_en, rise, swp, werr;
    logic [AW:0] pa;
    #2;
    exp_gnt = !rst && !disp_req && eng_req;
    exp_en  = !rst && (disp_req || (eng_req && !(eng_we && !eng_bank)));
    werr    = 1'b0;
    chk("eng_gnt", 32'(eng_gnt), 32'(exp_gnt));
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (!rst) begin
      if (disp_req) begin
        pa = {m_front, disp_addr};
        chk("disp_mem_addr", 32'(mem_addr), 32'(pa));
        chk("disp_mem_we", 32'(mem_we), 32'd0);
        sb.push_back('{is_disp: 1'b1, data: sh_rd(pa), t: $time});
      end else if (eng_req) begin
        pa = {m_front ^ eng_bank, eng_addr};
        if (!eng_we) begin
          chk("eng_rd_addr", 32'(mem_addr), 32'(pa));
          sb.push_back('{is_disp: 1'b0, data: sh_rd(pa), t: $time});
        end else if (eng_bank) begin
          chk("eng_wr_addr", 32'(mem_addr), 32'(pa));
          chk("eng_wr_we", 32'(mem_we), 32'd1);
          chk("eng_wr_data", 32'(mem_wdata), 32'(eng_wdata));
          shadow[int'(pa)] = eng_wdata;
        end else begin
          werr = 1'b1;
        end
      end
    end
    rise = in_blank && !m_blank;
    swp  = rise && (m_pend || gen_done);
    @(posedge clk);
    if (rst) begin
      m_front = 1'b0; m_pend = 1'b0; m_blank = 1'b0; m_err = 1'b0; m_ack = 1'b0; m_cnt = 16'd0;
    end else begin
      m_blank = in_blank;
      m_err   = m_err | werr;
      m_ack   = swp;
      m_pend  = !swp && (m_pend || gen_done);
      if (swp) begin
        m_front = ~m_front;
        m_cnt   = m_cnt + 16'd1;
      end
    end
    #2;
    chk("bank_sel", 32'(bank_sel), 32'(m_front));
    chk("swap_pending", 32'(swap_pending), 32'(m_pend));
    chk("gen_cnt", 32'(gen_cnt), 32'(m_cnt));
    chk("eng_wr_err", 32'(eng_wr_err), 32'(m_err));
    chk("swap_ack", 32'(swap_ack), 32'(m_ack));
  endtask

  task automatic idle();
    rst = 1'b0; disp_req = 1'b0; eng_req = 1'b0; eng_we = 1'b0; eng_bank = 1'b0;
    gen_done = 1'b0; disp_addr = '0; eng_addr = '0; eng_wdata = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sb.delete();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic keep;
    m_front = 1'b0; m_pend = 1'b0; m_blank = 1'b0; m_err = 1'b0; m_ack = 1'b0; m_cnt = 16'd0;
    idle();
    in_blank = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    // Requests during reset must not be granted.
    disp_req = 1'b1; eng_req = 1'b1;
    do_reset(2);
    idle();

    disp_req = 1'b1; disp_addr = 13'h005;
    tick();
    idle(); tick();

    // Engine read of back bank stalls behind display for three cycles.
    disp_req = 1'b1; disp_addr = 13'h044;
    eng_req = 1'b1; eng_we = 1'b0; eng_bank = 1'b1; eng_addr = 13'h123;
    repeat (3) tick();
    disp_req = 1'b0;
    tick();
    idle(); tick(); tick();

    eng_req = 1'b1; eng_we = 1'b1; eng_bank = 1'b1; eng_addr = 13'h010; eng_wdata = ~pat({1'b1, 13'h010});
    tick();
    eng_we = 1'b0;
    tick();
    eng_we = 1'b1; eng_bank = 1'b0; eng_wdata = 1'b1;
    tick();
    idle(); repeat (3) tick();

    // Pend then swap on blank rise; display afterwards reads the new front bank.
    gen_done = 1'b1; tick();
    gen_done = 1'b0; tick();
    in_blank = 1'b1; tick();
    disp_req = 1'b1; disp_addr = 13'h003; tick();
    idle();
    gen_done = 1'b1; tick();
    gen_done = 1'b0; repeat (3) tick();
    in_blank = 1'b0; tick();
    gen_done = 1'b1; in_blank = 1'b1; tick();
    gen_done = 1'b0; in_blank = 1'b0; tick();
    gen_done = 1'b1; in_blank = 1'b1; tick();
    gen_done = 1'b0; in_blank = 1'b0; tick();
    gen_done = 1'b1; tick();
    tick();
    gen_done = 1'b0;
    // Reads issued in the swap cycle use the old bank.
    disp_req = 1'b1; disp_addr = 13'h007; in_blank = 1'b1; tick();
    disp_req = 1'b0; eng_req = 1'b1; eng_bank = 1'b1; eng_addr = 13'h007; tick();
    idle(); in_blank = 1'b0; tick();

    gen_done = 1'b1; tick();
    gen_done = 1'b0; do_reset(1);
    tick();
    disp_req = 1'b1; disp_addr = 13'h009; tick();
    disp_req = 1'b0; do_reset(1);
    idle(); tick(); tick();

    // Walk gen_cnt to 0xFFFF with back-to-back swaps, then wrap.
    for (int i = 0; i < 65535; i++) begin
      in_blank = 1'b1; gen_done = 1'b1;
      @(posedge clk); #2;
      in_blank = 1'b0; gen_done = 1'b0;
      @(posedge clk); #2;
    end
    m_cnt = 16'hFFFF; m_front = 1'b1; m_blank = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
    tick();
    chk("gen_cnt_preload", 32'(gen_cnt), 32'h0000FFFF);
    in_blank = 1'b1; gen_done = 1'b1; tick();
    chk("gen_cnt_wrap", 32'(gen_cnt), 32'h0);
    idle(); in_blank = 1'b0; tick();

    for (int i = 0; i < 3000; i++) begin
      keep = eng_req && disp_req;
      disp_req  = ($urandom_range(0, 99) < 40);
      disp_addr = AW'($urandom_range(0, 63));
      if (!keep) begin
        eng_req   = ($urandom_range(0, 99) < 60);
        eng_we    = 1'($urandom_range(0, 1));
        eng_bank  = ($urandom_range(0, 99) < 85);
        eng_addr  = AW'($urandom_range(0, 63));
        eng_wdata = DW'($urandom_range(0, 1));
      end
      gen_done = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 20) in_blank = ~in_blank;
      tick();
    end
    idle(); tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
